// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory MMIO decoder.
// I/O page register offsets (byte offsets within the 256-byte page).
// Helper for sizing occupancy counters.
package dmem_mmio_pkg;

  localparam logic [7:0] MMIO_TXDATA = 8'h00;
  localparam logic [7:0] MMIO_STATUS = 8'h04;
  localparam logic [7:0] MMIO_CYCLE  = 8'h08;
  localparam logic [7:0] MMIO_TOHOST = 8'h0C;

  // STATUS bit positions; count field starts at STATUS_CNT_LSB
  localparam int STATUS_FULL    = 0;
  localparam int STATUS_EMPTY   = 1;
  localparam int STATUS_OVF     = 2;
  localparam int STATUS_CNT_LSB = 4;

  // Counter width able to hold the values 0..depth inclusive
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dmem_mmio_if.sv
// Bundle of every bus between the core/RAM/TX sink and the MMIO decoder.
// master = environment side (core, RAM, character sink); slave = decoder.
// Purely wiring, no logic.
interface dmem_mmio_if #(
  parameter int WIDTH = 32,
  parameter int DADDR = 16
);
  logic [DADDR-1:0] dmem_addr;
  logic [WIDTH-1:0] dmem_wdata;
  logic [3:0]       dmem_wr_en;
  logic [WIDTH-1:0] dmem_rdata;
  logic [DADDR-1:0] ram_addr;
  logic [WIDTH-1:0] ram_wdata;
  logic [3:0]       ram_wr_en;
  logic [WIDTH-1:0] ram_rdata;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             halt;
  logic [WIDTH-1:0] exit_code;

  modport master (
    output dmem_addr, dmem_wdata, dmem_wr_en, ram_rdata, tx_ready,
    input  dmem_rdata, ram_addr, ram_wdata, ram_wr_en, tx_data, tx_valid,
           halt, exit_code
  );

  modport slave (
    input  dmem_addr, dmem_wdata, dmem_wr_en, ram_rdata, tx_ready,
    output dmem_rdata, ram_addr, ram_wdata, ram_wr_en, tx_data, tx_valid,
           halt, exit_code
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with show-ahead read data.
// Latency: a push becomes visible on dout/empty one cycle later (no bypass).
// Backpressure: push while full is dropped unless a pop happens the same cycle.
module sync_fifo
  import dmem_mmio_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot the push needs, so full+pop still accepts
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// Splits core data accesses between data RAM and a small I/O page (TX FIFO, status, cycle, tohost).
// Latency: reads combinational (0 cycles); writes take effect on the next rising edge.
// Backpressure: TX stream is valid/ready; pushes into a full FIFO without a same-cycle pop set sticky overflow.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               DADDR      = 16,
  parameter logic [DADDR-1:0] IO_BASE    = 16'hFF00,
  parameter int               FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  dmem_mmio_if.slave  bus
);

  localparam int CW = count_width(FIFO_DEPTH);

  logic             io_sel;
  logic [7:0]       offset;
  logic             io_wr;
  logic             wr_txdata;
  logic             wr_status;
  logic             wr_tohost;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [CW-1:0]    fifo_count;
  logic [7:0]       fifo_dout;
  logic             overflow;
  logic [31:0]      cycle;
  logic             halt_q;
  logic [WIDTH-1:0] exit_q;
  logic [WIDTH-1:0] io_rdata;

  // Page decode: only the upper address bits select the I/O page; low two bits are don't-care
  assign io_sel = (bus.dmem_addr[DADDR-1:8] == IO_BASE[DADDR-1:8]);
  assign offset = bus.dmem_addr[7:0] & 8'hFC;
  assign io_wr  = io_sel & ~reset;

  assign wr_txdata = io_wr & bus.dmem_wr_en[0] & (offset == MMIO_TXDATA);
  assign wr_status = io_wr & bus.dmem_wr_en[0] & (offset == MMIO_STATUS);
  // tohost latches once: zero writes and writes after halt are ignored
  assign wr_tohost = io_wr & (|bus.dmem_wr_en) & (offset == MMIO_TOHOST)
                   & (bus.dmem_wdata != '0) & ~halt_q;

  assign bus.ram_addr  = bus.dmem_addr;
  assign bus.ram_wdata = bus.dmem_wdata;
  assign bus.ram_wr_en = io_sel ? 4'b0000 : bus.dmem_wr_en;

  assign fifo_pop     = ~fifo_empty & bus.tx_ready;
  assign bus.tx_valid = ~fifo_empty;
  assign bus.tx_data  = fifo_dout;
  assign bus.halt      = halt_q;
  assign bus.exit_code = exit_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .din   (bus.dmem_wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sticky overflow: set by a dropped push, cleared by any STATUS write
  always_ff @(posedge clk) begin
    if (reset)                                      overflow <= 1'b0;
    else if (wr_txdata & fifo_full & ~fifo_pop)     overflow <= 1'b1;
    else if (wr_status)                             overflow <= 1'b0;
  end

  // Free-running cycle counter, frozen once the program has halted
  always_ff @(posedge clk) begin
    if (reset)        cycle <= '0;
    else if (~halt_q) cycle <= cycle + 32'd1;
  end

  // Halt latch and exit code capture
  always_ff @(posedge clk) begin
    if (reset) begin
      halt_q <= 1'b0;
      exit_q <= '0;
    end else if (wr_tohost) begin
      halt_q <= 1'b1;
      exit_q <= bus.dmem_wdata;
    end
  end

  // I/O register read mux
  always_comb begin
    io_rdata = '0;
    case (offset)
      MMIO_STATUS: begin
        io_rdata[STATUS_FULL]            = fifo_full;
        io_rdata[STATUS_EMPTY]           = fifo_empty;
        io_rdata[STATUS_OVF]             = overflow;
        io_rdata[STATUS_CNT_LSB +: CW]   = fifo_count;
      end
      MMIO_CYCLE:  io_rdata = WIDTH'(cycle);
      MMIO_TOHOST: io_rdata = exit_q;
      default:     io_rdata = '0;
    endcase
  end

  assign bus.dmem_rdata = io_sel ? io_rdata : bus.ram_rdata;

endmodule
